knn_vote: RTL

- Final stage of the digit-recognition pipeline; sits directly downstream of the update_knn leaves.
- Consumes the per-image stream of nearest-neighbour candidates (distance, label) produced by the update_knn units, merged by the BFT.
- Keeps the K globally smallest candidates, runs a majority vote and emits one predicted digit label per test image on a 32-bit stream.
- Wrapped by a standard leaf (leaf_interface, 1 in / 1 out) exactly like other user blocks.

---
 rtl/knn_vote.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/knn_vote.sv
// knn_vote: keeps the K smallest (distance, label) candidates of one test image,
// majority-votes them and emits the label. Optional KNN_VOTE_DIST_OUT_EN adds min distance/count.
module knn_vote #(
  parameter int N_CAND     = 6,
  parameter int K          = 3,
  parameter int DIST_BITS  = 8,
  parameter int LABEL_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ap_start,
  input  logic [31:0] Input_1_V_TDATA,
  input  logic        Input_1_V_TVALID,
  output logic        Input_1_V_TREADY,
  output logic [31:0] Output_1_V_TDATA,
  output logic        Output_1_V_TVALID,
  input  logic        Output_1_V_TREADY
);
  // state   | meaning
  // COLLECT | accept N_CAND candidates, insertion-sort valid ones into the list
  // VOTE    | K cycles, one list entry examined per cycle
  // OUT     | present the result word until the downstream handshake
  typedef enum logic [1:0] {COLLECT, VOTE, OUT} state_t;

  localparam int CW = $clog2(N_CAND + 1);
  localparam int VW = (K > 1) ? $clog2(K) : 1;
  localparam int BW = $clog2(K + 1);
  localparam logic [LABEL_BITS-1:0] LABEL_INV = '1;
  localparam logic [LABEL_BITS-1:0] LABEL_MAX = LABEL_BITS'(9);

  state_t                 state, state_nx;
  logic [DIST_BITS-1:0]   dist_q  [K];
  logic [LABEL_BITS-1:0]  label_q [K];
  logic [DIST_BITS-1:0]   dist_ins  [K];
  logic [LABEL_BITS-1:0]  label_ins [K];
  logic [K-1:0]           gt;
  logic [CW-1:0]          cand_cnt;
  logic [VW-1:0]          vote_idx;
  logic [BW-1:0]          best_count, vote_cnt;
  logic [LABEL_BITS-1:0]  best_label;
  logic                   tready_q, tvalid_q;
  logic [31:0]            tdata_q, out_word;
  logic                   accept, last_cand, vote_last, vote_hit, handshake;

  logic [DIST_BITS-1:0]   in_dist;
  logic [LABEL_BITS-1:0]  in_label;
  logic                   unused_in_bits;

  assign in_dist        = Input_1_V_TDATA[DIST_BITS-1:0];
  assign in_label       = Input_1_V_TDATA[DIST_BITS+LABEL_BITS-1:DIST_BITS];
  assign unused_in_bits = ^Input_1_V_TDATA[31:DIST_BITS+LABEL_BITS];

  assign accept    = (state == COLLECT) && tready_q && Input_1_V_TVALID;
  assign last_cand = (cand_cnt == CW'(N_CAND - 1));
  assign vote_last = (vote_idx == VW'(K - 1));
  assign handshake = (state == OUT) && tvalid_q && Output_1_V_TREADY;

  assign Input_1_V_TREADY  = tready_q;
  assign Output_1_V_TVALID = tvalid_q;
  assign Output_1_V_TDATA  = tdata_q;

  // Sorted list keeps valid entries first, so gt is a thermometer code and the
  // first set bit is the insertion slot; equal distances land behind older ones.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      gt[i] = (label_q[i] > LABEL_MAX) || (dist_q[i] > in_dist);
    end
    dist_ins[0]  = gt[0] ? in_dist  : dist_q[0];
    label_ins[0] = gt[0] ? in_label : label_q[0];
    for (int i = 1; i < K; i++) begin
      if (!gt[i]) begin
        dist_ins[i]  = dist_q[i];
        label_ins[i] = label_q[i];
      end else if (!gt[i-1]) begin
        dist_ins[i]  = in_dist;
        label_ins[i] = in_label;
      end else begin
        dist_ins[i]  = dist_q[i-1];
        label_ins[i] = label_q[i-1];
      end
    end
  end

  always_comb begin
    vote_cnt = '0;
    for (int j = 0; j < K; j++) begin
      if ((label_q[j] <= LABEL_MAX) && (label_q[j] == label_q[vote_idx]))
        vote_cnt = vote_cnt + BW'(1);
    end
    vote_hit = (label_q[vote_idx] <= LABEL_MAX) && (vote_cnt > best_count);
  end

  always_comb begin
    out_word = '0;
    out_word[LABEL_BITS-1:0] = best_label;
`ifdef KNN_VOTE_DIST_OUT_EN
    out_word[DIST_BITS+7:8] = dist_q[0];
    out_word[31:28]         = 4'(best_count);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (accept && last_cand) state_nx = VOTE;
      VOTE:    if (vote_last)           state_nx = OUT;
      OUT:     if (handshake)           state_nx = COLLECT;
      default:                          state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= '1;
        label_q[i] <= LABEL_INV;
      end
      cand_cnt   <= '0;
      vote_idx   <= '0;
      best_count <= '0;
      best_label <= LABEL_INV;
      tready_q   <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
    end else begin
      tready_q <= (state_nx == COLLECT) && ap_start;
      case (state)
        COLLECT: if (accept) begin
          cand_cnt <= cand_cnt + CW'(1);
          if (in_label <= LABEL_MAX) begin
            dist_q  <= dist_ins;
            label_q <= label_ins;
          end
          if (last_cand) begin
            vote_idx   <= '0;
            best_count <= '0;
            best_label <= LABEL_INV;
          end
        end
        VOTE: begin
          if (vote_hit) begin
            best_count <= vote_cnt;
            best_label <= label_q[vote_idx];
          end
          vote_idx <= vote_idx + VW'(1);
        end
        OUT: begin
          // first OUT cycle latches the word; later cycles wait for the handshake
          if (!tvalid_q) begin
            tvalid_q <= 1'b1;
            tdata_q  <= out_word;
          end else if (Output_1_V_TREADY) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            cand_cnt <= '0;
            for (int i = 0; i < K; i++) begin
              dist_q[i]  <= '1;
              label_q[i] <= LABEL_INV;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
